// File: rtl/fp_norm_pack_pipe.sv
// fp_norm_pack_pipe: two-stage valid/ready result packer for the MAC datapath.
// Takes the normalised sum (leading one at the top bit) plus the exponent terms,
// and produces a packed {sign, exponent, mantissa} float. Rounding is either
// truncate or round-to-nearest-even using guard/sticky bits. Tiny results are
// denormalised by a right shift, and large results overflow to infinity.
// Flags: overflow, underflow, inexact.
//
// Build option: define FP_PACK_SAT_EN to saturate overflowing results to the
// largest finite magnitude instead of infinity. The overflow flag is still set.
module fp_norm_pack_pipe #(
    parameter int EXP_W    = 5,
    parameter int MAN_W    = 10,
    parameter int GRD_W    = 3,
    parameter int DIFF_W   = 5,
    parameter int Q_W      = 5,
    parameter int BIAS_ADJ = 9,
    parameter int FE_W     = EXP_W + 3,
    localparam int SUM_W   = MAN_W + 1 + GRD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SUM_W-1:0]   in_sum,
    input  logic [DIFF_W-1:0]  in_exp_diff,
    input  logic               in_exp_carry,
    input  logic               in_sign,
    input  logic [EXP_W:0]     in_max_exp,
    input  logic [Q_W-1:0]     in_q_frac,
    input  logic               in_rnd_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [EXP_W+MAN_W:0] out_data,
    output logic               out_ovf,
    output logic               out_unf,
    output logic               out_inx
);

    localparam int SH_W = $clog2(SUM_W + 2);
    localparam int PK_W = EXP_W + MAN_W;
    localparam logic signed [FE_W-1:0] FE_ONE    = FE_W'(1);
    localparam logic signed [FE_W-1:0] FE_SH_MAX = FE_W'(SUM_W + 1);
    localparam logic signed [FE_W-1:0] FE_OVF    = FE_W'((1 << EXP_W) - 1);

    // Pipeline enables: a stage advances when its downstream slot is free or draining.
    logic s2_en;
    logic s1_en;

    // Stage-1 registers.
    logic                    s1_valid;
    logic [SUM_W-1:0]        s1_sum;
    logic signed [FE_W-1:0]  s1_fe;
    logic                    s1_zero;
    logic                    s1_tiny;
    logic [SH_W-1:0]         s1_sh;
    logic                    s1_sign;
    logic                    s1_rnd;

    // Stage-1 combinational terms.
    logic signed [FE_W-1:0]  max_ext;
    logic signed [FE_W-1:0]  diff_ext;
    logic signed [FE_W-1:0]  carry_ext;
    logic signed [FE_W-1:0]  q_ext;
    logic signed [FE_W-1:0]  bias_ext;
    logic signed [FE_W-1:0]  fe_c;
    logic signed [FE_W-1:0]  sh_full;
    logic                    tiny_c;
    logic [SH_W-1:0]         sh_c;

    // Stage-2 combinational terms.
    logic [SUM_W-1:0]        drop_mask;
    logic                    dropped;
    logic [SUM_W-2:0]        x_low;
    logic [MAN_W-1:0]        man;
    logic                    g_bit;
    logic                    sticky;
    logic [EXP_W-1:0]        expf;
    logic                    round_up;
    logic                    ovf_pre;
    logic [PK_W-1:0]         packed_c;
    logic                    ovf_c;
    logic                    inx_c;
    logic                    unf_c;
    logic [PK_W:0]           data_c;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;

    // Stage-1 exponent equation, tiny detection and denormalising shift amount.
    always_comb begin
        max_ext   = FE_W'(in_max_exp);
        diff_ext  = FE_W'($signed(in_exp_diff));
        carry_ext = FE_W'(in_exp_carry);
        q_ext     = FE_W'(in_q_frac);
        bias_ext  = FE_W'(BIAS_ADJ);
        fe_c      = max_ext + diff_ext + carry_ext - bias_ext - q_ext;
        tiny_c    = (fe_c < FE_ONE);
        sh_full   = FE_ONE - fe_c;
        sh_c      = '0;
        if (tiny_c) begin
            // Anything past SUM_W+1 shifts the whole sum out; clamp keeps sh_c narrow.
            if (sh_full > FE_SH_MAX) begin
                sh_c = SH_W'(SUM_W + 1);
            end else begin
                sh_c = SH_W'(sh_full);
            end
        end
    end

    // Stage-1 register: capture the sum and the precomputed exponent terms.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_fe    <= '0;
            s1_zero  <= 1'b0;
            s1_tiny  <= 1'b0;
            s1_sh    <= '0;
            s1_sign  <= 1'b0;
            s1_rnd   <= 1'b0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sum  <= in_sum;
                s1_fe   <= fe_c;
                s1_zero <= (in_sum == '0);
                s1_tiny <= tiny_c;
                s1_sh   <= sh_c;
                s1_sign <= in_sign;
                s1_rnd  <= in_rnd_mode;
            end
        end
    end

    // Stage-2 datapath: denormalise, extract guard/sticky, round, handle overflow.
    always_comb begin
        drop_mask = ~({SUM_W{1'b1}} << s1_sh);
        dropped   = |(s1_sum & drop_mask);
        // The hidden-bit position is not stored, so only the lower SUM_W-1 bits matter.
        x_low     = (SUM_W-1)'(s1_sum >> s1_sh);
        man       = x_low[SUM_W-2:GRD_W];
        g_bit     = x_low[GRD_W-1];
        sticky    = (|x_low[GRD_W-2:0]) | dropped;
        expf      = s1_tiny ? '0 : s1_fe[EXP_W-1:0];
        round_up  = s1_rnd & g_bit & (sticky | man[0]);
        ovf_pre   = !s1_tiny && (s1_fe >= FE_OVF);

        // A mantissa carry ripples into the exponent: subnormal->normal, max->inf.
        packed_c  = {expf, man} + PK_W'(round_up);
        if (ovf_pre) begin
            packed_c = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end

        ovf_c = &packed_c[PK_W-1:MAN_W];
`ifdef FP_PACK_SAT_EN
        if (ovf_c) begin
            packed_c = {{(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        end
`endif
        inx_c = g_bit | sticky;
        unf_c = s1_tiny & inx_c;

        if (s1_zero) begin
            packed_c = '0;
            ovf_c    = 1'b0;
            inx_c    = 1'b0;
            unf_c    = 1'b0;
        end
        data_c = {s1_sign, packed_c};
    end

    // Stage-2 register: output slot, held stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
            out_inx   <= 1'b0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= data_c;
                out_ovf  <= ovf_c;
                out_unf  <= unf_c;
                out_inx  <= inx_c;
            end
        end
    end

endmodule
